// File: rtl/dump_pkg.sv
// dump_pkg: stream tags, dumper states and the register-mask walker shared by arch_state_dumper.
package dump_pkg;
    localparam logic [2:0] TAG_CYC  = 3'd0;
    localparam logic [2:0] TAG_PC   = 3'd1;
    localparam logic [2:0] TAG_REG  = 3'd2;
    localparam logic [2:0] TAG_MEM  = 3'd3;
    localparam logic [2:0] TAG_CSUM = 3'd4;
    typedef enum logic [2:0] {IDLE, HDR, REG, MEM, FETCH, CSUM} state_t;
    // Lowest set bit of mask at or above from; 32 when there is none.
    function automatic logic [5:0] next_set_bit(input logic [31:0] mask, input logic [5:0] from);
        logic [5:0] r;
        r = 6'd32;
        for (int i = 31; i >= 0; i--)
            if (mask[i] && 6'(i) >= from) r = 6'(i);
        return r;
    endfunction
endpackage

// File: rtl/dump_rd_stage.sv
// dump_rd_stage: read-latency adapter; adds the FETCH cycle for RD_LAT=1 and keeps a presented word
// stable until it is accepted.
module dump_rd_stage #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_tag,
    input  logic [IDX_W-1:0]  i_index,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_tag,
    output logic [IDX_W-1:0]  out_index,
    output logic              o_fire
);
    assign o_fire    = out_valid & out_ready;
    assign out_tag   = i_tag;
    assign out_index = i_index;
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign out_valid = i_req;
            assign out_data  = i_data;
        end else begin : g_lat1
            logic              r_ready;
            logic              r_held;
            logic [DATA_W-1:0] r_data;
            // First presented cycle shows the port data live and captures it; later stall cycles replay the copy.
            always_ff @(posedge clk) begin
                if (reset || !i_req || o_fire) begin
                    r_ready <= 1'b0;
                    r_held  <= 1'b0;
                end else begin
                    r_ready <= 1'b1;
                    r_held  <= r_ready;
                end
                if (r_ready && !r_held) r_data <= i_data;
            end
            assign out_valid = i_req & r_ready;
            assign out_data  = r_held ? r_data : i_data;
        end
    endgenerate
endmodule

// File: rtl/arch_state_dumper.sv
// arch_state_dumper: freezes the CPU and streams cycle count, PC, masked registers and a memory window.
// Define DUMP_CHECKSUM_EN to append an XOR checksum word (tag 4) to every frame.
module arch_state_dumper
    import dump_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          REG_N     = 32,
    parameter int          REG_AW    = $clog2(REG_N),
    parameter logic [31:0] REG_MASK  = 32'h03FF_FF00,
    parameter int          MEM_BASE  = 0,
    parameter int          MEM_WORDS = 64,
    parameter int          MEM_AW    = 8,
    parameter int          RD_LAT    = 1,
    parameter int          PERIOD    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [DATA_W-1:0] pc_in,
    output logic              cpu_stall,
    output logic [REG_AW-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_tag,
    output logic [MEM_AW-1:0] out_index,
    output logic              busy,
    output logic [7:0]        missed
);
    localparam int                PMAX      = PERIOD > 0 ? PERIOD - 1 : 0;
    localparam int                PW        = PMAX > 0 ? $clog2(PMAX + 1) : 1;
    localparam logic [5:0]        REG_LIM   = 6'(REG_N);
    localparam logic [MEM_AW-1:0] MEM_FIRST = MEM_AW'(MEM_BASE);
    localparam logic [MEM_AW-1:0] MEM_LAST  = MEM_AW'(MEM_BASE + MEM_WORDS - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_cyc_cnt;
    logic [DATA_W-1:0] r_cap_cyc;
    logic [DATA_W-1:0] r_cap_pc;
    logic [PW-1:0]     r_per_cnt;
    logic              r_pc_word;
    logic [REG_AW-1:0] r_reg;
    logic [MEM_AW-1:0] r_mem;
    logic [7:0]        r_missed;
    logic              w_start;
    logic              w_fire;
    logic [5:0]        w_first;
    logic [5:0]        w_next;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_tail;
    logic [2:0]        w_tag;
    logic [MEM_AW-1:0] w_index;

`ifdef DUMP_CHECKSUM_EN
    localparam state_t MEM_DONE = CSUM;
    logic [DATA_W-1:0] r_csum;
    always_ff @(posedge clk) begin
        if (reset || r_state == IDLE) r_csum <= '0;
        else if (w_fire && r_state != CSUM) r_csum <= r_csum ^ w_data;
    end
    assign w_tail = r_csum;
`else
    localparam state_t MEM_DONE = IDLE;
    assign w_tail = '0;
`endif

    assign busy      = r_state != IDLE;
    assign cpu_stall = busy;
    assign reg_addr  = r_reg;
    assign mem_addr  = r_mem;
    assign missed    = r_missed;
    assign w_start   = trig || (PERIOD > 0 && r_per_cnt == PW'(PMAX));
    assign w_first   = next_set_bit(REG_MASK, 6'd0);
    assign w_next    = next_set_bit(REG_MASK, 6'(r_reg) + 6'd1);

    always_comb begin
        w_tag   = r_state == HDR ? (r_pc_word ? TAG_PC : TAG_CYC) :
                  r_state == REG ? TAG_REG : r_state == MEM ? TAG_MEM : TAG_CSUM;
        w_index = r_state == REG ? MEM_AW'(r_reg) : r_state == MEM ? r_mem : '0;
        w_data  = r_state == HDR ? (r_pc_word ? r_cap_pc : r_cap_cyc) :
                  r_state == REG ? reg_data : r_state == MEM ? mem_data : w_tail;
    end

    dump_rd_stage #(.DATA_W(DATA_W), .IDX_W(MEM_AW), .RD_LAT(RD_LAT)) u_rd (
        .clk       (clk),
        .reset     (reset),
        .i_req     (busy),
        .i_data    (w_data),
        .i_tag     (w_tag),
        .i_index   (w_index),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_index (out_index),
        .o_fire    (w_fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cyc_cnt <= '0;
            r_per_cnt <= '0;
            r_missed  <= '0;
            r_reg     <= '0;
            r_mem     <= '0;
            r_pc_word <= 1'b0;
            r_cap_cyc <= '0;
            r_cap_pc  <= '0;
        end else begin
            if (!cpu_stall) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_start) r_per_cnt <= '0;
            else if (!cpu_stall && PERIOD > 0) r_per_cnt <= r_per_cnt + 1'b1;
            if (w_start && busy && r_missed != 8'hFF) r_missed <= r_missed + 8'd1;
            // Addresses advance only on a transfer, so the read ports stay put while the sink stalls.
            case (r_state)
                IDLE: if (w_start) begin
                    r_state   <= HDR;
                    r_pc_word <= 1'b0;
                    r_cap_cyc <= r_cyc_cnt;
                    r_cap_pc  <= pc_in;
                end
                HDR: if (w_fire) begin
                    r_pc_word <= 1'b1;
                    if (r_pc_word) begin
                        if (w_first < REG_LIM) begin
                            r_state <= REG;
                            r_reg   <= REG_AW'(w_first);
                        end else begin
                            r_state <= MEM;
                            r_mem   <= MEM_FIRST;
                        end
                    end
                end
                REG: if (w_fire) begin
                    if (w_next < REG_LIM) r_reg <= REG_AW'(w_next);
                    else begin
                        r_state <= MEM;
                        r_mem   <= MEM_FIRST;
                    end
                end
                MEM: if (w_fire) begin
                    if (r_mem == MEM_LAST) r_state <= MEM_DONE;
                    else r_mem <= r_mem + 1'b1;
                end
                default: if (w_fire) r_state <= IDLE;
            endcase
        end
    end
endmodule
